pkt_generator: RTL and testbench
================================

# pkt_generator

Timed AXI4-Stream packet source: the transmit-side counterpart of the per-second packet counter. Emits fixed-length test packets on a master AXI4-Stream port at a programmed number of packets per one-second window, and reports how many packets were sent in the last completed window. It sits in the `clk_200` domain ahead of the switch data path. It is used for rate and throughput checks against the receive-side counters.

## Interface
Parameters:
- `C_M_AXIS_DATA_WIDTH`, 256, tdata width in bits; tkeep is `C_M_AXIS_DATA_WIDTH/8`.
- `C_M_AXIS_TUSER_WIDTH`, 128, tuser width.
- `REG_DEPTH`, 32, width of the rate, sequence and counter registers.
- `TICKS_PER_SEC`, 32'hBEBC200, clock cycles per window; simulation uses 32'h106E.

Ports:
- `clk_200`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits new packet starts.
- `pkt_rate`  in  REG_DEPTH  packets allowed per window.
- `pkt_len`  in  16  packet length in beats; 0 means send nothing.
- `src_port`  in  8  value placed in tuser[23:16].
- `m_axis_tdata`  out  C_M_AXIS_DATA_WIDTH  beat payload.
- `m_axis_tkeep`  out  C_M_AXIS_DATA_WIDTH/8  always all ones while tvalid, 0 otherwise.
- `m_axis_tuser`  out  C_M_AXIS_TUSER_WIDTH  metadata.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of packet.
- `sent_counter`  out  REG_DEPTH  packets completed in the previous window.
- `busy`  out  1  high while in SEND.

## Operation
- Window timer counts 0..`TICKS_PER_SEC`-1 and then wraps. In the wrap cycle:
  - `sent_counter` <= window count, including a packet whose last beat handshakes in that same cycle;
  - window count <= 0;
  - credit <= `pkt_rate`.
- Unused credit is discarded at the wrap.
- FSM states are IDLE and SEND.
- IDLE -> SEND when `enable` && credit != 0 && `pkt_len` != 0. On that transition:
  - latch `pkt_len` into len_q;
  - beat <= 0;
  - credit <= credit-1.
- SEND: a beat is transferred when tvalid && tready.
  - On transfer with beat != len_q-1: beat <= beat+1.
  - On transfer with beat == len_q-1: go to IDLE, seq <= seq+1, window count +1.
- Beat content:
  - tdata[31:0]=seq;
  - tdata[47:32]=beat index;
  - all remaining tdata bits 0.
- tuser[15:0] = len_q*(C_M_AXIS_DATA_WIDTH/8), wrapping at 16 bits. tuser[23:16] = src_port latched at packet start. All other tuser bits are 0.
- tlast = (beat == len_q-1) while in SEND.
- Mid-packet `enable` deassert: the current packet completes and no new packet starts.
- Mid-packet window wrap: the packet continues and needs no new credit. It counts in the window where its last beat handshakes.
- Changes to `pkt_rate` take effect only at the next wrap. Changes to `pkt_len` take effect only at the next packet start.
- seq and the window count wrap modulo 2^REG_DEPTH.
- Credit is not reloaded by reset; it is 0 until the first wrap.

## Timing
- Reset values: every output 0 (tvalid, tlast, tkeep, tdata, tuser, sent_counter, busy); state IDLE; timer, credit, seq and window count 0.
- Reset is asynchronous: asserting it mid-packet drops tvalid immediately with no completion.
- All outputs are registered.
- tvalid rises the cycle after the IDLE start decision.
- After the last-beat handshake, tvalid is 0 for exactly one cycle minimum. Back-to-back packet starts are therefore spaced len+1 cycles apart at full tready.
- While tvalid && !tready, tdata, tuser, tkeep and tlast must be held stable.
- tvalid never depends combinationally on tready.
- First packet starts no earlier than 2 cycles after the first wrap.

## Test plan
- Reset: assert `reset` for 5 cycles with tready=1 -> all outputs 0 and no tvalid until after the first wrap (`TICKS_PER_SEC`=32'h106E).
- Basic rate: rate=3, len=4, tready=1, enable=1 -> exactly 3 packets of 4 beats per window. tlast is on beat index 3, seq=0,1,2, tuser[15:0]=128, one idle cycle between packets, and `sent_counter`=3 after the next wrap.
- Backpressure: rate=2, len=3, tready toggling 1010... -> every beat index 0..2 arrives once, in order, with tdata held stable across stalls, and `sent_counter`=2.
- Zero cases: rate=0 or len=0 -> tvalid stays 0 for two full windows and `sent_counter`=0.
- Enable drop: deassert `enable` on beat 1 of a len=5 packet -> beats 2..4 still sent with tlast on beat 4, then no further tvalid.
- Async reset mid-packet: pulse `reset` during beat 2 -> tvalid=0 within the same cycle. After re-enable and the next wrap, the first packet carries seq=0.

Source files
------------

// File: rtl/pkt_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pkt_generator
//  Purpose  : Timed AXI4-Stream packet source. Emits fixed-length test
//             packets at a programmed number of packets per one-second
//             window and reports the packets completed in the last window.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_200        in   clock, rising edge
//    reset          in   asynchronous active-high reset
//    enable         in   permits new packet starts
//    pkt_rate       in   packets allowed per window (loaded at wrap)
//    pkt_len        in   packet length in beats, 0 = send nothing
//    src_port       in   value placed in tuser[23:16]
//    m_axis_tdata   out  {0.., beat[15:0], seq[31:0]}
//    m_axis_tkeep   out  all ones while tvalid
//    m_axis_tuser   out  {0.., src_port, byte length}
//    m_axis_tvalid  out  beat valid
//    m_axis_tready  in   downstream ready
//    m_axis_tlast   out  last beat of packet
//    sent_counter   out  packets completed in previous window
//    busy           out  high while a packet is being sent
// ============================================================================
module pkt_generator #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          REG_DEPTH            = 32,
  parameter logic [31:0] TICKS_PER_SEC        = 32'hBEBC200
) (
  input  logic                              clk_200,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [REG_DEPTH-1:0]              pkt_rate,
  input  logic [15:0]                       pkt_len,
  input  logic [7:0]                        src_port,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [REG_DEPTH-1:0]              sent_counter,
  output logic                              busy
);

  localparam int          C_KEEP_W         = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [15:0] C_BYTES_PER_BEAT = 16'(C_KEEP_W);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [31:0]           r_timer;
  logic [REG_DEPTH-1:0]  r_credit;
  logic [REG_DEPTH-1:0]  r_seq;
  logic [REG_DEPTH-1:0]  r_win_cnt;
  logic [REG_DEPTH-1:0]  r_sent;
  logic [15:0]           r_len_q;
  logic [15:0]           r_beat;
  logic [15:0]           r_len_bytes;
  logic [7:0]            r_src;
  logic                  r_tlast;

  logic w_wrap;
  logic w_hs;
  logic w_last_hs;
  logic w_start;

  assign w_wrap    = (r_timer == TICKS_PER_SEC - 32'd1);
  assign w_hs      = (r_state == S_SEND) && m_axis_tready;
  assign w_last_hs = w_hs && r_tlast;
  assign w_start   = (r_state == S_IDLE) && enable &&
                     (r_credit != '0) && (pkt_len != 16'd0);

  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_credit    <= '0;
      r_seq       <= '0;
      r_win_cnt   <= '0;
      r_sent      <= '0;
      r_len_q     <= '0;
      r_beat      <= '0;
      r_len_bytes <= '0;
      r_src       <= '0;
      r_tlast     <= 1'b0;
    end else begin
      r_timer <= w_wrap ? 32'd0 : r_timer + 32'd1;

      // A packet finishing in the wrap cycle belongs to the closing window.
      if (w_wrap) begin
        r_sent    <= r_win_cnt + {{(REG_DEPTH-1){1'b0}}, w_last_hs};
        r_win_cnt <= '0;
      end else if (w_last_hs) begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end

      // Reload discards any leftover credit from the closing window.
      if (w_wrap) begin
        r_credit <= pkt_rate;
      end else if (w_start) begin
        r_credit <= r_credit - 1'b1;
      end

      if (w_last_hs) begin
        r_seq <= r_seq + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_SEND;
            r_len_q     <= pkt_len;
            r_beat      <= '0;
            r_tlast     <= (pkt_len == 16'd1);
            r_src       <= src_port;
            r_len_bytes <= pkt_len * C_BYTES_PER_BEAT;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_state <= S_IDLE;
              r_tlast <= 1'b0;
            end else begin
              r_beat  <= r_beat + 16'd1;
              // Next beat is the last one when beat+1 == len-1.
              r_tlast <= ((r_beat + 16'd2) == r_len_q);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = (r_state == S_SEND);
  assign busy          = (r_state == S_SEND);
  assign m_axis_tkeep  = {C_KEEP_W{m_axis_tvalid}};
  assign m_axis_tlast  = r_tlast;
  assign sent_counter  = r_sent;

  // Payload and metadata are pure register fields, zeroed outside SEND.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tuser = '0;
    if (r_state == S_SEND) begin
      m_axis_tdata[31:0]  = 32'(r_seq);
      m_axis_tdata[47:32] = r_beat;
      m_axis_tuser[15:0]  = r_len_bytes;
      m_axis_tuser[23:16] = r_src;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_generator
//  Purpose  : Directed self-checking bench for pkt_generator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_generator;

  localparam int          DW  = 256;
  localparam int          UW  = 128;
  localparam int          RD  = 32;
  localparam logic [31:0] TPS = 32'h106E;
  localparam int          T   = 4206;

  logic           clk_200 = 1'b0;
  logic           reset   = 1'b1;
  logic           enable  = 1'b0;
  logic [RD-1:0]  pkt_rate = '0;
  logic [15:0]    pkt_len  = '0;
  logic [7:0]     src_port = '0;
  logic [DW-1:0]  m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [RD-1:0]  sent_counter;
  logic           busy;

  pkt_generator #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .REG_DEPTH           (RD),
    .TICKS_PER_SEC       (TPS)
  ) dut (
    .clk_200      (clk_200),
    .reset        (reset),
    .enable       (enable),
    .pkt_rate     (pkt_rate),
    .pkt_len      (pkt_len),
    .src_port     (src_port),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .sent_counter (sent_counter),
    .busy         (busy)
  );

  always #5 clk_200 = ~clk_200;

  // Independent window timer model used only to know where wraps fall.
  int tb_t;
  int tb_wraps;
  always @(posedge clk_200 or posedge reset) begin
    if (reset) tb_t <= 0;
    else if (tb_t == T-1) begin
      tb_t     <= 0;
      tb_wraps <= tb_wraps + 1;
    end else tb_t <= tb_t + 1;
  end

  int passed;
  int total;

  // Monitor state filled by step().
  bit tog;
  int step_idx;
  int nvalid;
  int stall_bad;
  bit prev_stall;
  logic [DW+UW+DW/8:0] prev_bus;
  int q_seq[$], q_beat[$], q_last[$], q_u16[$], q_src[$], q_ok[$], q_cyc[$];

  task automatic clear_mon();
    step_idx = 0; nvalid = 0; stall_bad = 0; prev_stall = 0;
    q_seq.delete(); q_beat.delete(); q_last.delete(); q_u16.delete();
    q_src.delete(); q_ok.delete(); q_cyc.delete();
  endtask

  task automatic step();
    @(negedge clk_200);
    if (tog) m_axis_tready = ~m_axis_tready;
    step_idx++;
    if (m_axis_tvalid) nvalid++;
    if (prev_stall && ({m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tkeep} !== prev_bus))
      stall_bad++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_bus   = {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tkeep};
    if (m_axis_tvalid && m_axis_tready) begin
      q_seq.push_back(int'(m_axis_tdata[31:0]));
      q_beat.push_back(int'(m_axis_tdata[47:32]));
      q_last.push_back(int'(m_axis_tlast));
      q_u16.push_back(int'(m_axis_tuser[15:0]));
      q_src.push_back(int'(m_axis_tuser[23:16]));
      q_ok.push_back(int'((m_axis_tkeep == '1) && (m_axis_tdata[DW-1:48] == '0) &&
                          (m_axis_tuser[UW-1:24] == '0)));
      q_cyc.push_back(step_idx);
    end
  endtask

  task automatic run_to_wrap();
    int w0;
    bit hit;
    w0 = tb_wraps; hit = 0;
    for (int i = 0; i < T + 20; i++) begin
      step();
      if (tb_wraps != w0) begin hit = 1; break; end
    end
    if (!hit) begin
      $display("FAIL wrap_timeout: got no wrap, required wrap within %0d cycles", T+20);
      total++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; pkt_rate = 3; pkt_len = 4; src_port = 8'hA5;
    m_axis_tready = 1'b1; tog = 0;
    repeat (5) @(negedge clk_200);
    if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %0b required 0", m_axis_tvalid); else passed++; total++;
    if (m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %0b required 0", m_axis_tlast); else passed++; total++;
    if (m_axis_tkeep !== '0) $display("FAIL rst_tkeep: got %h required 0", m_axis_tkeep); else passed++; total++;
    if (m_axis_tdata !== '0) $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); else passed++; total++;
    if (m_axis_tuser !== '0) $display("FAIL rst_tuser: got %h required 0", m_axis_tuser); else passed++; total++;
    if (sent_counter !== '0) $display("FAIL rst_sent: got %0d required 0", sent_counter); else passed++; total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", busy); else passed++; total++;
    reset = 1'b0;
    clear_mon();
    run_to_wrap();
    if (nvalid !== 0) $display("FAIL rst_no_valid_before_wrap: got %0d valid cycles required 0", nvalid); else passed++; total++;
    if (sent_counter !== 0) $display("FAIL rst_first_wrap_sent: got %0d required 0", sent_counter); else passed++; total++;
  endtask

  task automatic test_basic_rate();
    clear_mon();
    repeat (50) step();
    // Prepare the next window's settings; credit is already spent.
    pkt_rate = 2; pkt_len = 3; src_port = 8'h3C; tog = 1;
    run_to_wrap();
    if (q_seq.size() !== 12) $display("FAIL basic_beat_count: got %0d required 12", q_seq.size()); else passed++; total++;
    if (q_seq.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        int k, b;
        k = i / 4; b = i % 4;
        if (q_seq[i] !== k || q_beat[i] !== b || q_last[i] !== int'(b == 3) || q_u16[i] !== 128 ||
            q_src[i] !== 'hA5 || q_ok[i] !== 1 || q_cyc[i] !== 1 + 5*k + b)
          $display("FAIL basic_beat%0d: got seq=%0d beat=%0d last=%0d len=%0d src=%0h ok=%0d cyc=%0d required seq=%0d beat=%0d last=%0d len=128 src=a5 ok=1 cyc=%0d",
                   i, q_seq[i], q_beat[i], q_last[i], q_u16[i], q_src[i], q_ok[i], q_cyc[i], k, b, int'(b == 3), 1 + 5*k + b);
        else passed++;
        total++;
      end
    end
    if (sent_counter !== 3) $display("FAIL basic_sent: got %0d required 3", sent_counter); else passed++; total++;
  endtask

  task automatic test_backpressure();
    clear_mon();
    repeat (100) step();
    pkt_rate = 0;
    run_to_wrap();
    tog = 0; m_axis_tready = 1'b1;
    if (q_seq.size() !== 6) $display("FAIL bp_beat_count: got %0d required 6", q_seq.size()); else passed++; total++;
    if (q_seq.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        int k, b;
        k = 3 + i / 3; b = i % 3;
        if (q_seq[i] !== k || q_beat[i] !== b || q_last[i] !== int'(b == 2) || q_u16[i] !== 96 ||
            q_src[i] !== 'h3C || q_ok[i] !== 1)
          $display("FAIL bp_beat%0d: got seq=%0d beat=%0d last=%0d len=%0d src=%0h ok=%0d required seq=%0d beat=%0d last=%0d len=96 src=3c ok=1",
                   i, q_seq[i], q_beat[i], q_last[i], q_u16[i], q_src[i], q_ok[i], k, b, int'(b == 2));
        else passed++;
        total++;
      end
    end
    if (stall_bad !== 0) $display("FAIL bp_stall_stable: got %0d changes during stall required 0", stall_bad); else passed++; total++;
    if (sent_counter !== 2) $display("FAIL bp_sent: got %0d required 2", sent_counter); else passed++; total++;
  endtask

  task automatic test_zero_cases();
    // Two windows with rate=0.
    clear_mon(); run_to_wrap();
    if (nvalid !== 0 || sent_counter !== 0) $display("FAIL zero_rate_w1: got valid=%0d sent=%0d required 0/0", nvalid, sent_counter); else passed++; total++;
    clear_mon();
    repeat (100) step();
    pkt_rate = 3; pkt_len = 0;
    run_to_wrap();
    if (nvalid !== 0 || sent_counter !== 0) $display("FAIL zero_rate_w2: got valid=%0d sent=%0d required 0/0", nvalid, sent_counter); else passed++; total++;
    // Two windows with len=0 and non-zero credit.
    clear_mon(); run_to_wrap();
    if (nvalid !== 0 || sent_counter !== 0) $display("FAIL zero_len_w1: got valid=%0d sent=%0d required 0/0", nvalid, sent_counter); else passed++; total++;
    clear_mon(); run_to_wrap();
    if (nvalid !== 0 || sent_counter !== 0) $display("FAIL zero_len_w2: got valid=%0d sent=%0d required 0/0", nvalid, sent_counter); else passed++; total++;
  endtask

  task automatic test_enable_drop();
    bit hit;
    pkt_len = 5;
    clear_mon();
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_axis_tvalid && m_axis_tdata[47:32] == 16'd1) begin hit = 1; break; end
    end
    if (!hit) $display("FAIL en_beat1_timeout: got no beat 1 required beat 1 within 20 cycles"); else passed++; total++;
    enable = 1'b0;
    repeat (40) step();
    if (q_seq.size() !== 5 || nvalid !== 5) $display("FAIL en_beat_count: got beats=%0d valid=%0d required 5/5", q_seq.size(), nvalid); else passed++; total++;
    if (q_seq.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        if (q_seq[i] !== 5 || q_beat[i] !== i || q_last[i] !== int'(i == 4) || q_u16[i] !== 160 || q_ok[i] !== 1)
          $display("FAIL en_beat%0d: got seq=%0d beat=%0d last=%0d len=%0d ok=%0d required seq=5 beat=%0d last=%0d len=160 ok=1",
                   i, q_seq[i], q_beat[i], q_last[i], q_u16[i], q_ok[i], i, int'(i == 4));
        else passed++;
        total++;
      end
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    enable = 1'b1;
    clear_mon();
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_axis_tvalid && m_axis_tdata[47:32] == 16'd2) begin hit = 1; break; end
    end
    if (!hit) $display("FAIL ar_beat2_timeout: got no beat 2 required beat 2 within 20 cycles"); else passed++; total++;
    if (m_axis_tdata[31:0] !== 32'd6) $display("FAIL ar_seq_before: got %0d required 6", m_axis_tdata[31:0]); else passed++; total++;
    #2 reset = 1'b1;
    #1;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL ar_drop: got tvalid=%0b busy=%0b required 0/0", m_axis_tvalid, busy); else passed++; total++;
    @(negedge clk_200);
    reset = 1'b0;
    clear_mon();
    run_to_wrap();
    if (nvalid !== 0 || sent_counter !== 0) $display("FAIL ar_quiet_window: got valid=%0d sent=%0d required 0/0", nvalid, sent_counter); else passed++; total++;
    clear_mon();
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_axis_tvalid) begin hit = 1; break; end
    end
    if (!hit || step_idx !== 1 || m_axis_tdata[31:0] !== 32'd0 || m_axis_tdata[47:32] !== 16'd0)
      $display("FAIL ar_first_pkt: got hit=%0b cyc=%0d seq=%0d beat=%0d required 1/1/0/0",
               hit, step_idx, m_axis_tdata[31:0], m_axis_tdata[47:32]);
    else passed++;
    total++;
  endtask

  initial begin
    passed = 0; total = 0; tog = 0;
    test_reset();
    test_basic_rate();
    test_backpressure();
    test_zero_cases();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
